// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcode and sequencer state types for the ALU front end
package alu_pkg;

    localparam int WIDTH = 5;
    localparam int OPW   = 3;

    typedef enum logic [OPW-1:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_ROL = 3'd6,
        OP_ROR = 3'd7
    } alu_op_t;

    localparam logic [OPW-1:0] OP_LAST = OP_ROR;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        HOLD    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - three-beat operand/opcode collector with registered, flagged ALU result
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter logic [OPW-1:0] OP_LAST_P = OP_LAST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_r,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [WIDTH-1:0] ROT_LIMIT = WIDTH[WIDTH-1:0];

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    logic             op_illegal;
    logic             rot_range;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        out_valid_d  = out_valid_q;
        in_ready     = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_OP);
        accept       = in_valid && in_ready;
        // widened compare keeps the check meaningful when OP_LAST_P is the top code
        op_illegal   = {1'b0, alu_op_q} > {1'b0, OP_LAST_P};
        rot_range    = ((alu_op_q == OP_ROL) || (alu_op_q == OP_ROR)) && (alu_b_q >= ROT_LIMIT);

        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    alu_a_d = in_data;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (accept) begin
                    alu_b_d = in_data;
                    state_d = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (accept) begin
                    alu_op_d = in_data[OPW-1:0];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                out_result_d = op_illegal ? '0 : alu_r;
                out_err_d    = op_illegal || rot_range;
                out_valid_d  = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_NOP;
        end else begin
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result_q <= '0;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;
    assign out_valid  = out_valid_q;

endmodule
